// File: rtl/serial_word_comparator_if.sv
// Bus bundle for serial_word_comparator: frame control, serial operand bits
// and the registered frame verdicts.
//
// Handshake: start is honoured only while the comparator is idle (busy=0);
// bit_valid qualifies x/y as the next MSB-first frame bit and is honoured only
// while a frame is running; done pulses for one cycle when the results are
// valid. There is no back-pressure: an accepted bit is consumed on that edge.
interface serial_word_comparator_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic          start;
  logic          bit_valid;
  logic          x;
  logic          y;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic          lt;
  logic [CW-1:0] mismatch_cnt;

  // Producer side: drives frame control and operand bits.
  modport master (
    output start, bit_valid, x, y,
    input  busy, done, eq, gt, lt, mismatch_cnt
  );

  // Comparator side.
  modport slave (
    input  start, bit_valid, x, y,
    output busy, done, eq, gt, lt, mismatch_cnt
  );
endinterface

// File: rtl/serial_word_comparator.sv
// Frame-level magnitude/equality comparator for two MSB-first serial streams.
// The first differing bit fixes the ordering; every differing bit is counted.
// All outputs are registered; state_dbg exposes the FSM state.
module serial_word_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_word_comparator_if.slave  bus,
  output logic [1:0]               state_dbg
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] run_mm;
  logic          decided;
  logic          a_gt;

  logic          diff;
  logic [CW-1:0] mm_next;
  logic          decided_next;
  logic          a_gt_next;

  assign state_dbg = state;

  // Effect of accepting the current bit pair: running count and first-difference latch.
  always_comb begin
    diff         = bus.x ^ bus.y;
    mm_next      = run_mm + CW'(diff);
    decided_next = decided | diff;
    a_gt_next    = decided ? a_gt : (bus.x & ~bus.y);
  end

  // Frame FSM with registered handshake outputs and verdicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      run_mm           <= '0;
      decided          <= 1'b0;
      a_gt             <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.eq           <= 1'b0;
      bus.gt           <= 1'b0;
      bus.lt           <= 1'b0;
      bus.mismatch_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state            <= RUN;
            bus.busy         <= 1'b1;
            bit_cnt          <= '0;
            run_mm           <= '0;
            decided          <= 1'b0;
            a_gt             <= 1'b0;
            bus.eq           <= 1'b0;
            bus.gt           <= 1'b0;
            bus.lt           <= 1'b0;
            bus.mismatch_cnt <= '0;
          end
        end
        RUN: begin
          // bit_valid low is a stall: everything holds.
          if (bus.bit_valid) begin
            run_mm  <= mm_next;
            decided <= decided_next;
            a_gt    <= a_gt_next;
            if (bit_cnt == LAST_BIT) begin
              // Last bit: publish verdicts computed including this bit.
              state            <= DONE;
              bus.done         <= 1'b1;
              bus.eq           <= ~decided_next;
              bus.gt           <= decided_next & a_gt_next;
              bus.lt           <= decided_next & ~a_gt_next;
              bus.mismatch_cnt <= mm_next;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_word_comparator.md
# serial_word_comparator

Frame-level magnitude and equality comparator for two MSB-first serial bit streams. It sits directly downstream of the 1-bit equality cell and consumes the same `x`/`y` bit pair, one bit per accepted cycle. It turns a WIDTH-bit frame into registered `eq`/`gt`/`lt` verdicts plus a count of mismatching bit positions. A `start`/`bit_valid`/`done` handshake frames each comparison.

## Interface

- `WIDTH`, default 8: bits per frame; legal range 2..256.
- `CW`, default `$clog2(WIDTH+1)`: width of the mismatch counter; derived, never overridden.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a frame; sampled only in IDLE.
- `bit_valid`  in  1  qualifies `x`/`y` as the next frame bit; sampled only in RUN.
- `x`  in  1  serial operand A bit, MSB first.
- `y`  in  1  serial operand B bit, MSB first.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results are valid in this cycle.
- `eq`  out  1  A == B for the last completed frame.
- `gt`  out  1  A > B (unsigned) for the last completed frame.
- `lt`  out  1  A < B (unsigned) for the last completed frame.
- `mismatch_cnt`  out  CW  number of bit positions where x != y in the last frame.

## Operation

- **FSM states:** IDLE, RUN, DONE.
- **Reset:** state IDLE. `busy`=0, `done`=0, `eq`=0, `gt`=0, `lt`=0, `mismatch_cnt`=0. All internal counters and flags are cleared.
- **IDLE:** `bit_valid` is ignored.
  - `start`=1 -> RUN.
  - At the same time: `eq`/`gt`/`lt`/`mismatch_cnt` clear to 0, bit counter = 0, `decided` = 0.
- **RUN:** on each edge with `bit_valid`=1:
  - Bit counter increments.
  - If x != y, the running mismatch count increments.
  - If x != y and `decided`=0: set `decided`=1 and latch `a_gt` = x & ~y. The first differing bit (MSB-first) decides the ordering; later bits never change it.
  - When the accepted bit is the WIDTH-th, go to DONE. At that edge, register the outputs:
    - `eq` = ~decided_next
    - `gt` = decided_next & a_gt_next
    - `lt` = decided_next & ~a_gt_next
    - `mismatch_cnt` = final count, including this bit
  - `bit_valid`=0 is a stall. State and counters hold, with no limit on stall length.
  - `start` is ignored in RUN.
- **DONE:** `done`=1 for exactly this cycle, then unconditional return to IDLE. `start` and `bit_valid` are ignored in DONE.
- **Result hold:** `eq`/`gt`/`lt`/`mismatch_cnt` hold their values from DONE through IDLE until the next accepted `start` clears them.
- **One-hot result:** exactly one of `eq`/`gt`/`lt` is 1 whenever a result is valid. All three are 0 between reset or `start` and `done`.
- **Counter range:** `mismatch_cnt` never exceeds WIDTH; the CW width guarantees no wrap. The internal bit counter is compared against WIDTH-1 for termination and never wraps.

## Timing

- `start` is sampled at edge T0. RUN is active from T0, and the earliest first bit is accepted at edge T0+1.
- With no stalls, the last bit is accepted at edge T0+WIDTH. `done`/`busy`/results are visible in the cycle after that edge. The total start-to-done latency is WIDTH+1 cycles.
- `done` is high for exactly one cycle. `busy` falls with the edge that leaves DONE.
- **Back-to-back frames:** a new `start` is accepted at the first edge after `done` (IDLE). The minimum frame period is therefore WIDTH+2 cycles.
- **Mid-frame reset:** asynchronous `rst` forces IDLE and zeroes all outputs immediately, without waiting for a clock. The partial frame is discarded, and no `done` is produced for it.
- **Output registration:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan

All scenarios use WIDTH=8.

- **Reset values:** assert `rst` for 3 cycles, then release -> all outputs 0, `busy`=0. Pulse `bit_valid` with no `start` -> nothing changes.
- **Equal operands:** A=B=0xA5, no stalls -> `done` at cycle T0+9, `eq`=1, `gt`=`lt`=0, `mismatch_cnt`=0. Results hold 5 idle cycles later.
- **MSB decides:** A=0x80, B=0x7F -> `gt`=1, `eq`=`lt`=0, `mismatch_cnt`=8. A=0x3C, B=0x3D -> `lt`=1, `mismatch_cnt`=1 (LSB decides).
- **Stalls and ignored start:** A=0x5A, B=0x4B with random `bit_valid` gaps (total 20 cycles) and `start` pulsed during RUN -> single `done` after the 8th valid bit, `gt`=1, `mismatch_cnt`=2. The extra `start` has no effect.
- **Back-to-back frames:** frame 1 A=0x0F, B=0xF0, then `start` the cycle after `done`, frame 2 A=B=0x00. Required response:
  - Frame 1 gives `lt`=1, `mismatch_cnt`=8.
  - Outputs clear at the frame-2 `start`.
  - Frame 2 gives `eq`=1, `mismatch_cnt`=0.
  - `done` pulses exactly twice.
- **Reset mid-frame:** assert `rst` asynchronously after 4 bits of A=0xFF, B=0x00 -> outputs 0 within the reset. No `done` appears. A following A=0x01, B=0x01 frame gives `eq`=1, `mismatch_cnt`=0.
